// File: rtl/pc_sequencer.sv
// LEGv8 program-counter sequencer: PC register, PC+4 / branch-target adders,
// next-PC select and the IDLE/RUN/FLUSH/HALT fetch control FSM.
module pc_sequencer #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              branch,
    input  logic              cbz,
    input  logic              zero_flag,
    input  logic [WIDTH-1:0]  branch_offset,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  adder_1,
    output logic [WIDTH-1:0]  adder_2,
    output logic              mux_1_control,
    output logic              fetch_valid,
    output logic [1:0]        state,
    output logic [15:0]       branch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_pc_next;
    logic [15:0]        r_branch_count;
    logic [15:0]        w_branch_count_next;
    logic [WIDTH-1:0]   w_sum;
    logic               w_taken;
    logic               w_sel_target;

    // Both adders wrap modulo 2^WIDTH; the target is forced word-aligned.
    assign adder_1 = r_pc + WIDTH'(4);
    assign w_sum   = r_pc + branch_offset;
    assign adder_2 = {w_sum[WIDTH-1:2], 2'b00};

    assign w_taken = branch | (cbz & zero_flag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_pc           <= RESET_PC;
            r_branch_count <= '0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_branch_count <= w_branch_count_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_branch_count_next = r_branch_count;
        w_sel_target        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                // halt_req > stall > taken > sequential
                if (halt_req) begin
                    w_state_next = HALT;
                end else if (stall) begin
                    w_state_next = RUN;
                end else if (w_taken) begin
                    w_sel_target        = 1'b1;
                    w_pc_next           = adder_2;
                    w_branch_count_next = r_branch_count + 16'd1;
                    w_state_next        = FLUSH;
                end else begin
                    w_pc_next = adder_1;
                end
            end
            FLUSH: begin
                w_state_next = halt_req ? HALT : RUN;
            end
            HALT: begin
                if (start) w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign pc            = r_pc;
    assign mux_1_control = w_sel_target;
    assign fetch_valid   = (r_state == RUN);
    assign state         = r_state;
    assign branch_count  = r_branch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance exercises a wrapping RESET_PC.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        halt_req;
    logic        branch;
    logic        cbz;
    logic        zero_flag;
    logic [31:0] branch_offset;

    logic [31:0] pc,  adder_1,  adder_2;
    logic        mux_1_control,  fetch_valid;
    logic [1:0]  state;
    logic [15:0] branch_count;

    logic [31:0] pc2, adder_1_2, adder_2_2;
    logic        mux_1_control_2, fetch_valid_2;
    logic [1:0]  state_2;
    logic [15:0] branch_count_2;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .halt_req(halt_req), .branch(branch), .cbz(cbz), .zero_flag(zero_flag),
        .branch_offset(branch_offset), .pc(pc), .adder_1(adder_1),
        .adder_2(adder_2), .mux_1_control(mux_1_control),
        .fetch_valid(fetch_valid), .state(state), .branch_count(branch_count)
    );

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .halt_req(halt_req), .branch(branch), .cbz(cbz), .zero_flag(zero_flag),
        .branch_offset(branch_offset), .pc(pc2), .adder_1(adder_1_2),
        .adder_2(adder_2_2), .mux_1_control(mux_1_control_2),
        .fetch_valid(fetch_valid_2), .state(state_2), .branch_count(branch_count_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_core(input string tag, input logic [31:0] e_pc, input logic [1:0] e_st,
                              input logic e_fv, input logic [15:0] e_bc);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".state"}, {30'd0, state}, {30'd0, e_st});
        check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
        check({tag, ".branch_count"}, {16'd0, branch_count}, {16'd0, e_bc});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
        branch = 1'b0; cbz = 1'b0; zero_flag = 1'b0; branch_offset = '0;
        #2;
        check_core("reset", 32'h0, 2'd0, 1'b0, 16'd0);
        check("reset.mux", {31'd0, mux_1_control}, 32'd0);
        check("reset.adder_1", adder_1, 32'h4);
        check("reset.adder_2", adder_2, 32'h0);
        check("wrap.reset_pc", pc2, 32'hFFFF_FFFC);
        check("wrap.adder_1", adder_1_2, 32'h0);

        step(); reset = 1'b0;
        step();
        check_core("idle_hold", 32'h0, 2'd0, 1'b0, 16'd0);

        start = 1'b1;
        step(); start = 1'b0;
        check_core("start", 32'h0, 2'd1, 1'b1, 16'd0);
        check("wrap.start_pc", pc2, 32'hFFFF_FFFC);
        step(); check("seq1", pc, 32'h4);
        check("wrap.pc_wraps", pc2, 32'h0);
        step(); check("seq2", pc, 32'h8);
        step(); check("seq3", pc, 32'hC);
        step(); check_core("seq4", 32'h10, 2'd1, 1'b1, 16'd0);

        // Unconditional branch from 0x10 by +0x40; held through FLUSH to show it is ignored
        branch = 1'b1; branch_offset = 32'h40; #1;
        check("b.mux", {31'd0, mux_1_control}, 32'd1);
        check("b.adder_2", adder_2, 32'h50);
        step();
        check_core("b.flush", 32'h50, 2'd2, 1'b0, 16'd1);
        check("flush.mux", {31'd0, mux_1_control}, 32'd0);
        step(); branch = 1'b0;
        check_core("b.resume", 32'h50, 2'd1, 1'b1, 16'd1);

        branch = 1'b1; branch_offset = 32'hFFFF_FFD0;
        step(); branch = 1'b0;
        check_core("b_back", 32'h20, 2'd2, 1'b0, 16'd2);
        step(); check_core("b_back.run", 32'h20, 2'd1, 1'b1, 16'd2);

        cbz = 1'b1; zero_flag = 1'b0; branch_offset = 32'hFFFF_FFF0; #1;
        check("cbz_nt.mux", {31'd0, mux_1_control}, 32'd0);
        step();
        check_core("cbz_nt", 32'h24, 2'd1, 1'b1, 16'd2);
        // Misaligned offset: 0x24 - 0xD = 0x17, target forced down to 0x14
        zero_flag = 1'b1; branch_offset = 32'hFFFF_FFF3; #1;
        check("cbz_t.mux", {31'd0, mux_1_control}, 32'd1);
        step(); cbz = 1'b0; zero_flag = 1'b0;
        check_core("cbz_t", 32'h14, 2'd2, 1'b0, 16'd3);
        step(); check_core("cbz_t.run", 32'h14, 2'd1, 1'b1, 16'd3);

        branch = 1'b1; branch_offset = 32'h1C;
        step(); branch = 1'b0;
        check("to_30", pc, 32'h30);
        step();

        stall = 1'b1; branch = 1'b1; branch_offset = 32'h10; #1;
        check("stall.mux", {31'd0, mux_1_control}, 32'd0);
        step(); check_core("stall1", 32'h30, 2'd1, 1'b1, 16'd4);
        step(); check_core("stall2", 32'h30, 2'd1, 1'b1, 16'd4);
        stall = 1'b0; #1;
        check("unstall.mux", {31'd0, mux_1_control}, 32'd1);
        step(); branch = 1'b0;
        check_core("unstall.b", 32'h40, 2'd2, 1'b0, 16'd5);
        step(); check_core("unstall.run", 32'h40, 2'd1, 1'b1, 16'd5);

        halt_req = 1'b1; stall = 1'b1; branch = 1'b1; #1;
        check("halt.mux", {31'd0, mux_1_control}, 32'd0);
        step(); stall = 1'b0; branch = 1'b0;
        check_core("halt", 32'h40, 2'd3, 1'b0, 16'd5);
        step(); halt_req = 1'b0;
        check_core("halt.again", 32'h40, 2'd3, 1'b0, 16'd5);
        step();
        start = 1'b1;
        step(); start = 1'b1;
        check_core("resume", 32'h40, 2'd1, 1'b1, 16'd5);
        step(); start = 1'b0;
        check_core("resume.seq_start_ignored", 32'h44, 2'd1, 1'b1, 16'd5);

        // branch and cbz together with zero_flag=0 still take the branch
        branch = 1'b1; cbz = 1'b1; zero_flag = 1'b0; branch_offset = 32'h8; #1;
        check("b_cbz.mux", {31'd0, mux_1_control}, 32'd1);
        step(); branch = 1'b0; cbz = 1'b0;
        check_core("b_cbz", 32'h4C, 2'd2, 1'b0, 16'd6);

        halt_req = 1'b1;
        step(); halt_req = 1'b0;
        check_core("flush_halt", 32'h4C, 2'd3, 1'b0, 16'd6);
        start = 1'b1;
        step(); start = 1'b0;
        branch = 1'b1; branch_offset = 32'h100;
        step(); branch = 1'b0;
        check_core("pre_reset_flush", 32'h14C, 2'd2, 1'b0, 16'd7);

        // Asynchronous reset mid-FLUSH, no clock edge in between
        #2; reset = 1'b1; #1;
        check_core("async_reset", 32'h0, 2'd0, 1'b0, 16'd0);
        check("async_reset.mux", {31'd0, mux_1_control}, 32'd0);
        check("async_reset.wrap_pc", pc2, 32'hFFFF_FFFC);
        step(); reset = 1'b0;
        step();
        check_core("post_reset_idle", 32'h0, 2'd0, 1'b0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Sequences the LEGv8 program counter. Holds the PC register, computes the sequential (PC+4) and branch-target candidates, and drives the 2:1 next-PC select that chooses between them. It decides branches (B, CBZ), stalls, one-cycle post-branch flush, and halt/resume. Sits at the front of the fetch stage, between the control unit and instruction memory.

## Interface
Parameters:
- WIDTH, 32, PC and address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  leave IDLE or HALT and begin/resume fetching.
- stall  input  1  hold the PC this cycle; honoured in RUN only.
- halt_req  input  1  stop fetching; enter HALT.
- branch  input  1  unconditional branch (B) decoded this cycle.
- cbz  input  1  CBZ decoded this cycle.
- zero_flag  input  1  ALU zero result for CBZ.
- branch_offset  input  WIDTH  sign-extended, already shifted byte offset.
- pc  output  WIDTH  current PC (registered).
- adder_1  output  WIDTH  pc + 4 (combinational).
- adder_2  output  WIDTH  branch target (combinational).
- mux_1_control  output  1  1 = select adder_2 as next PC (combinational).
- fetch_valid  output  1  1 = instruction at pc is valid this cycle.
- state  output  2  IDLE=0, RUN=1, FLUSH=2, HALT=3.
- branch_count  output  16  count of taken branches (registered).

## Operation
- Arithmetic: adder_1 = pc + 4 and adder_2 = (pc + branch_offset) with bits [1:0] forced to 0. Both are modulo 2^WIDTH, so they wrap silently (0xFFFF_FFFC + 4 = 0). No overflow flag.
- taken = branch | (cbz & zero_flag).
- Priority in RUN: halt_req > stall > taken > sequential.
- State transitions:
  - IDLE: pc held. start=1 -> RUN. Otherwise stay.
  - RUN:
    - halt_req -> HALT, pc held.
    - Else stall -> stay in RUN, pc held.
    - Else taken -> pc <= adder_2, branch_count increments, go to FLUSH.
    - Else pc <= adder_1, stay in RUN.
  - FLUSH: pc held. halt_req -> HALT, else RUN. stall, branch and cbz are ignored.
  - HALT: pc held. start=1 -> RUN, resuming at the held pc. halt_req has no further effect.
- mux_1_control = (state==RUN) & ~halt_req & ~stall & taken. It is 0 in all other cases.
- fetch_valid = 1 only in RUN.
- branch_count wraps from 0xFFFF to 0.
- branch and cbz asserted together: treated as taken (branch dominates).
- start asserted in RUN or FLUSH: ignored.

## Timing
- Reset (asynchronous, effective immediately, mid-operation included): pc = RESET_PC, state = IDLE, branch_count = 0, fetch_valid = 0, mux_1_control = 0. adder_1 and adder_2 follow the reset pc.
- IDLE to first valid fetch: start sampled at edge N; fetch_valid = 1 after edge N, at pc = RESET_PC.
- Sequential fetch: one PC per cycle, latency 1 clock from decision to new pc.
- Taken branch sampled at edge N:
  - pc = target after edge N.
  - fetch_valid = 0 for exactly one cycle (FLUSH).
  - Fetch of the target is valid after edge N+1.
- Stall: pc unchanged at each edge where stall=1 in RUN; fetch_valid stays 1.
- halt_req at edge N: fetch_valid = 0 after edge N. Resume on start at edge M: fetch_valid = 1 after edge M, at the same pc.
- Reset deassertion is sampled synchronously. The first state change may occur on the first edge after reset falls.

## Test plan
- Reset then start, no branches for 4 cycles -> pc sequence 0x0, 0x4, 0x8, 0xC. fetch_valid = 1 from the cycle after start. state = RUN.
- At pc=0x10, branch=1, branch_offset=0x40 -> mux_1_control=1 that cycle. pc=0x50 and fetch_valid=0 next cycle. fetch_valid=1 the cycle after. branch_count=1.
- At pc=0x20, cbz=1: with zero_flag=0 -> pc=0x24 next. With zero_flag=1 and offset=0xFFFF_FFF0 -> pc=0x10 next, then a FLUSH cycle.
- At pc=0x30, stall=1 and branch=1 for 2 cycles, then stall=0 -> pc held at 0x30 for 2 cycles, mux_1_control=0 while stalled. Branch is taken on the first unstalled cycle.
- halt_req with stall and branch in the same cycle at pc=0x40 -> HALT, pc=0x40, branch_count unchanged. start 3 cycles later -> RUN at 0x40.
- Corner cases:
  - RESET_PC=0xFFFF_FFFC, start -> pc wraps to 0x0.
  - reset asserted mid-FLUSH -> pc = RESET_PC, state = IDLE immediately, without waiting for a clock edge.
